// File: rtl/bcd_cascade_ctrl.sv
// ============================================================================
//  Module      : bcd_cascade_ctrl
//  Description : Enable/clear sequencer for a units+tens BCD counter cascade
//                that counts 00..terminal, wraps to 00 and emits a tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_cascade_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] term_bcd,
    input  logic [3:0] cnt_u,
    input  logic [3:0] cnt_t,
    output logic       en_u,
    output logic       en_t,
    output logic       clr_u,
    output logic       clr_t,
    output logic       tick,
    output logic       busy,
    output logic       cfg_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLR   = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_UWRAP = 3'd3;
    localparam logic [2:0] c_TWRAP = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_term;
    logic       r_clr_u;
    logic       r_clr_t;
    logic       r_tick;
    logic       r_busy;
    logic       r_cfg_err;

    logic       w_at_term;
    logic       w_u_nine;
    logic       w_term_ok;
    logic       w_en_u;
    logic       w_en_t;

    assign w_at_term = ({cnt_t, cnt_u} == r_term);
    assign w_u_nine  = (cnt_u == 4'd9);
    assign w_term_ok = (term_bcd[7:4] <= 4'd9) && (term_bcd[3:0] <= 4'd9) &&
                       (term_bcd != 8'h00);

    // Units are never enabled at 9; the tens step takes that edge instead.
    always_comb begin
        w_en_u = 1'b0;
        w_en_t = 1'b0;
        if (r_state == c_RUN && !stop) begin
            if (!w_at_term) begin
                if (w_u_nine) begin
                    w_en_t = 1'b1;
                end else begin
                    w_en_u = 1'b1;
                end
            end
        end
    end

    // Clear/tick flops are loaded on entry to the state they belong to, so
    // the counters' async clears only ever see a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_term    <= 8'h00;
            r_clr_u   <= 1'b0;
            r_clr_t   <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_clr_u   <= 1'b0;
            r_clr_t   <= 1'b0;
            r_tick    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start && !stop) begin
                    if (w_term_ok) begin
                        r_term  <= term_bcd;
                        r_state <= c_CLR;
                        r_clr_u <= 1'b1;
                        r_clr_t <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cfg_err <= 1'b1;
                    end
                end
            end else if (stop) begin
                r_state <= c_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_CLR, c_UWRAP, c_TWRAP: begin
                        r_state <= c_RUN;
                    end
                    c_RUN: begin
                        if (w_at_term) begin
                            r_state <= c_TWRAP;
                            r_clr_u <= 1'b1;
                            r_clr_t <= 1'b1;
                            r_tick  <= 1'b1;
                        end else if (w_u_nine) begin
                            r_state <= c_UWRAP;
                            r_clr_u <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign en_u    = w_en_u;
    assign en_t    = w_en_t;
    assign clr_u   = r_clr_u;
    assign clr_t   = r_clr_t;
    assign tick    = r_tick;
    assign busy    = r_busy;
    assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_cascade_ctrl.sv
// ============================================================================
//  Module      : tb_bcd_cascade_ctrl
//  Description : Bench for bcd_cascade_ctrl with a behavioural counter pair
//                and a queue of expected per-cycle observations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_cascade_ctrl;

    typedef struct packed {
        logic [7:0] cnt;
        logic       en_u;
        logic       en_t;
        logic       clr_u;
        logic       clr_t;
        logic       tick;
        logic       busy;
        logic       cfg_err;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctr_rst;
    logic       start;
    logic       stop;
    logic [7:0] term_bcd;
    logic [3:0] cnt_u;
    logic [3:0] cnt_t;
    logic       en_u;
    logic       en_t;
    logic       clr_u;
    logic       clr_t;
    logic       tick;
    logic       busy;
    logic       cfg_err;
    logic       w_aclr_u;
    logic       w_aclr_t;

    int   errors = 0;
    int   checks = 0;
    rec_t q[$];

    always #5 clk = ~clk;

    bcd_cascade_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .term_bcd (term_bcd),
        .cnt_u    (cnt_u),
        .cnt_t    (cnt_t),
        .en_u     (en_u),
        .en_t     (en_t),
        .clr_u    (clr_u),
        .clr_t    (clr_t),
        .tick     (tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    // Decade counters: enable-driven, async clear, no self-wrap.
    assign w_aclr_u = clr_u | ctr_rst;
    assign w_aclr_t = clr_t | ctr_rst;

    always_ff @(posedge clk or posedge w_aclr_u) begin
        if (w_aclr_u) cnt_u <= 4'd0;
        else if (en_u) cnt_u <= cnt_u + 4'd1;
    end

    always_ff @(posedge clk or posedge w_aclr_t) begin
        if (w_aclr_t) cnt_t <= 4'd0;
        else if (en_t) cnt_t <= cnt_t + 4'd1;
    end

    function automatic rec_t observe();
        rec_t r;
        r.cnt     = {cnt_t, cnt_u};
        r.en_u    = en_u;
        r.en_t    = en_t;
        r.clr_u   = clr_u;
        r.clr_t   = clr_t;
        r.tick    = tick;
        r.busy    = busy;
        r.cfg_err = cfg_err;
        return r;
    endfunction

    function automatic rec_t idle_rec(input logic [7:0] c, input logic ce);
        rec_t r;
        r         = '0;
        r.cnt     = c;
        r.cfg_err = ce;
        return r;
    endfunction

    function automatic rec_t busy_rec(input logic [7:0] c, input logic cu, input logic ct);
        rec_t r;
        r       = '0;
        r.cnt   = c;
        r.clr_u = cu;
        r.clr_t = ct;
        r.busy  = 1'b1;
        return r;
    endfunction

    // One full wrap period of expected observations for terminal value t.
    task automatic push_period(input logic [7:0] t);
        rec_t       r;
        int         ulim;
        logic [7:0] v;
        for (int tn = 0; tn <= int'(t[7:4]); tn++) begin
            ulim = (tn == int'(t[7:4])) ? int'(t[3:0]) : 9;
            for (int un = 0; un <= ulim; un++) begin
                v      = {tn[3:0], un[3:0]};
                r      = busy_rec(v, 1'b0, 1'b0);
                r.en_u = (v != t) && (un != 9);
                r.en_t = (v != t) && (un == 9);
                q.push_back(r);
                if (un == 9 && v != t) begin
                    q.push_back(busy_rec({tn[3:0] + 4'd1, 4'd0}, 1'b1, 1'b0));
                end
            end
        end
        r      = busy_rec(8'h00, 1'b1, 1'b1);
        r.tick = 1'b1;
        q.push_back(r);
    endtask

    task automatic chk(input string tag, input rec_t exp);
        rec_t o;
        o = observe();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic chk_q(input string tag);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed=queue_empty expected=queued_record", tag);
        end else begin
            chk(tag, q.pop_front());
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic [7:0] t);
        @(negedge clk);
        start    = s;
        stop     = p;
        term_bcd = t;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        ctr_rst  = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        term_bcd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", idle_rec(8'h00, 1'b0));
        @(negedge clk);
        rst     = 1'b0;
        ctr_rst = 1'b0;

        // term 09, with an ignored start carrying a new term mid-run
        drive(1'b1, 1'b0, 8'h09);
        chk("t09_idle", idle_rec(8'h00, 1'b0));
        q.push_back(busy_rec(8'h00, 1'b1, 1'b1));
        push_period(8'h09);
        push_period(8'h09);
        for (int i = 0; i < 23; i++) begin
            drive(i == 5, 1'b0, (i == 5) ? 8'h03 : 8'h09);
            chk_q("t09_trace");
        end
        drive(1'b0, 1'b1, 8'h09);
        chk("t09_stop", busy_rec(8'h00, 1'b0, 1'b0));
        drive(1'b0, 1'b0, 8'h09);
        chk("t09_stopped", idle_rec(8'h00, 1'b0));

        // term 25, stop at 13
        drive(1'b1, 1'b0, 8'h25);
        chk("t25_idle", idle_rec(8'h00, 1'b0));
        q.push_back(busy_rec(8'h00, 1'b1, 1'b1));
        push_period(8'h25);
        while (q.size() > 0 && q[0].cnt != 8'h13) begin
            drive(1'b0, 1'b0, 8'h25);
            chk_q("t25_to13");
        end
        drive(1'b0, 1'b1, 8'h25);
        chk("stop_at13", busy_rec(8'h13, 1'b0, 1'b0));
        q.delete();
        repeat (2) begin
            drive(1'b0, 1'b0, 8'h25);
            chk("hold13", idle_rec(8'h13, 1'b0));
        end

        // restart from held 13: clears, then two full periods
        drive(1'b1, 1'b0, 8'h25);
        chk("restart_idle", idle_rec(8'h13, 1'b0));
        q.push_back(busy_rec(8'h00, 1'b1, 1'b1));
        push_period(8'h25);
        push_period(8'h25);
        for (int i = 0; i < 59; i++) begin
            drive(1'b0, 1'b0, 8'h25);
            chk_q("t25_trace");
        end
        drive(1'b0, 1'b1, 8'h25);
        chk("t25_stop", busy_rec(8'h00, 1'b0, 1'b0));
        drive(1'b0, 1'b0, 8'h25);
        chk("t25_stopped", idle_rec(8'h00, 1'b0));

        // start+stop together in IDLE
        drive(1'b1, 1'b1, 8'h09);
        chk("startstop_now", idle_rec(8'h00, 1'b0));
        drive(1'b0, 1'b0, 8'h09);
        chk("startstop_next", idle_rec(8'h00, 1'b0));

        // rejected configurations
        drive(1'b1, 1'b0, 8'h0A);
        chk("bad0A_now", idle_rec(8'h00, 1'b0));
        drive(1'b0, 1'b0, 8'h0A);
        chk("bad0A_err", idle_rec(8'h00, 1'b1));
        drive(1'b1, 1'b0, 8'h00);
        chk("bad00_now", idle_rec(8'h00, 1'b0));
        drive(1'b0, 1'b0, 8'h00);
        chk("bad00_err", idle_rec(8'h00, 1'b1));
        drive(1'b1, 1'b0, 8'hA0);
        chk("badA0_now", idle_rec(8'h00, 1'b0));
        drive(1'b0, 1'b0, 8'hA0);
        chk("badA0_err", idle_rec(8'h00, 1'b1));
        drive(1'b0, 1'b0, 8'h00);
        chk("err_pulse_end", idle_rec(8'h00, 1'b0));

        // reset asserted mid-count at 07
        drive(1'b1, 1'b0, 8'h09);
        chk("rstrun_idle", idle_rec(8'h00, 1'b0));
        q.push_back(busy_rec(8'h00, 1'b1, 1'b1));
        push_period(8'h09);
        while (q.size() > 0 && q[0].cnt != 8'h07) begin
            drive(1'b0, 1'b0, 8'h09);
            chk_q("rstrun_to07");
        end
        drive(1'b0, 1'b0, 8'h09);
        chk_q("rstrun_at07");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", idle_rec(8'h07, 1'b0));
        drive(1'b0, 1'b0, 8'h09);
        chk("rst_held", idle_rec(8'h07, 1'b0));
        rst = 1'b0;
        repeat (2) begin
            drive(1'b0, 1'b0, 8'h09);
            chk("rst_released", idle_rec(8'h07, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
